// File: rtl/c2h_scan_sched_pkg.sv
// Shared definitions for the sgdma C2H scan scheduler: state encodings,
// capture buffer depth and the packet-length decode.
package c2h_scan_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_IRQ     = 2'd3
  } state_t;

  localparam int FIFO_DEPTH_DEF = 64;

  localparam int                   PKT_LEN_W   = 13;
  localparam logic [PKT_LEN_W-1:0] PKT_LEN_MAX = 13'd4096;

  // A programmed length of zero stands for the maximum packet of 4096 beats.
  function automatic logic [PKT_LEN_W-1:0] pkt_len(input logic [11:0] beats);
    return (beats == 12'd0) ? PKT_LEN_MAX : {1'b0, beats};
  endfunction

endpackage

// File: rtl/c2h_sync_fifo.sv
// Synchronous capture buffer with full/empty flags, occupancy count,
// registered read data and a synchronous flush.
module c2h_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // NOTE: the storage array has no reset; only pointers and the read register
  // carry state that matters after reset, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_data  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_data  <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/c2h_scan_sched.sv
// Scan-frame capture into a buffer and C2H AXIS packetizer with per-packet
// and end-of-frame tlast, overflow counting and a frame-done interrupt.
module c2h_scan_sched
  import c2h_scan_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = 16,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst_n,
  input  logic                  c2h_run_i,
  input  logic                  c2h_rst_i,
  input  logic [11:0]           pkt_beats_i,
  input  logic [DATA_WIDTH-1:0] pcie_data,
  input  logic                  pcie_valid,
  input  logic                  pcie_start,
  input  logic                  pcie_stop,
  input  logic                  s0_axis_c2h_tready_i,
  output logic [DATA_WIDTH-1:0] s0_axis_c2h_tdata_o,
  output logic [KEEP_WIDTH-1:0] s0_axis_c2h_tkeep_o,
  output logic [KEEP_WIDTH-1:0] s0_axis_c2h_tuser_o,
  output logic                  s0_axis_c2h_tlast_o,
  output logic                  s0_axis_c2h_tvalid_o,
  output logic                  irq_req_o,
  input  logic                  irq_ack_i,
  output logic                  busy_o,
  output logic [15:0]           ovf_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                 state_q, state_d;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          occupancy;
  logic                   fifo_full, fifo_empty;
  logic                   start_fire, wr_req, wr_en, drop;
  logic                   out_ready, pop_ok, pop, closes_pkt, last_d;
  logic                   tvalid_q, tlast_q;
  logic [11:0]            beat_cnt_q;
  logic [PKT_LEN_W-1:0]   pkt_len_q;
  logic [15:0]            ovf_q;

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this purely combinational; a
  // path that leaves state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    if (c2h_rst_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (c2h_run_i && pcie_start && !pcie_stop) state_d = ST_CAPTURE;
        ST_CAPTURE: if (pcie_stop || !c2h_run_i)               state_d = ST_FLUSH;
        ST_FLUSH:   if (fifo_empty && !tvalid_q)               state_d = ST_IRQ;
        ST_IRQ:     if (irq_ack_i)                             state_d = ST_IDLE;
        default:                                               state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o    = (state_q != ST_IDLE);
    irq_req_o = (state_q == ST_IRQ);
  end

  assign start_fire = (state_q == ST_IDLE) && (state_d == ST_CAPTURE);
  assign wr_req     = pcie_valid && !c2h_rst_i && ((state_q == ST_CAPTURE) || start_fire);

  // The output register counts as one buffer slot, so at most FIFO_DEPTH
  // beats are held in total while the DMA stalls.
  assign occupancy  = fifo_count + CW'(tvalid_q);
  assign drop       = wr_req && (fifo_full || (occupancy >= CW'(FIFO_DEPTH)));
  assign wr_en      = wr_req && !drop;

  assign closes_pkt = (({1'b0, beat_cnt_q} + 13'd1) == pkt_len_q);
  assign out_ready  = !tvalid_q || s0_axis_c2h_tready_i;

  // While capturing, hold the newest beat back until a successor exists,
  // since only then is it known not to be the last beat of the frame.
  always_comb begin
    pop_ok = 1'b0;
    case (state_q)
      ST_CAPTURE: pop_ok = (fifo_count >= CW'(2)) || closes_pkt;
      ST_FLUSH:   pop_ok = 1'b1;
      default:    pop_ok = 1'b0;
    endcase
  end

  assign pop    = pop_ok && out_ready && !fifo_empty && !c2h_rst_i;
  assign last_d = closes_pkt || ((state_q == ST_FLUSH) && (fifo_count == CW'(1)));

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      beat_cnt_q <= '0;
      pkt_len_q  <= PKT_LEN_MAX;
      ovf_q      <= '0;
    end else begin
      if (c2h_rst_i)                  tvalid_q <= 1'b0;
      else if (pop) begin
        tvalid_q <= 1'b1;
        tlast_q  <= last_d;
      end else if (s0_axis_c2h_tready_i) tvalid_q <= 1'b0;

      if (c2h_rst_i || start_fire) beat_cnt_q <= '0;
      else if (pop)                beat_cnt_q <= last_d ? 12'd0 : beat_cnt_q + 12'd1;

      if (start_fire) pkt_len_q <= pkt_len(pkt_beats_i);

      if (start_fire)                    ovf_q <= '0;
      else if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  c2h_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (usr_clk),
    .rst_n   (usr_rst_n),
    .flush   (c2h_rst_i),
    .wr_en   (wr_en),
    .wr_data (pcie_data),
    .rd_en   (pop),
    .rd_data (s0_axis_c2h_tdata_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign s0_axis_c2h_tvalid_o = tvalid_q;
  assign s0_axis_c2h_tlast_o  = tlast_q;
  assign s0_axis_c2h_tkeep_o  = tvalid_q ? {KEEP_WIDTH{1'b1}} : {KEEP_WIDTH{1'b0}};
  assign s0_axis_c2h_tuser_o  = '0;
  assign ovf_cnt_o            = ovf_q;

endmodule

// File: doc/c2h_scan_sched.md
C2H_SCAN_SCHED -- requirements
Module: c2h_scan_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of the scan beat and AXIS tdata.
REQ-002 Parameter KEEP_WIDTH, default 16, width of tkeep/tuser (DATA_WIDTH/8).
REQ-003 Parameter FIFO_DEPTH, default 64, number of capture buffer entries (power of two).
REQ-004 Ports (name  direction  width  meaning):
 usr_clk  in  1  single clock.
 usr_rst_n  in  1  asynchronous active-low reset.
 c2h_run_i  in  1  channel enable from the test controller.
 c2h_rst_i  in  1  synchronous channel flush from the DMA core.
 pkt_beats_i  in  12  beats per AXIS packet; 0 means 4096.
 pcie_data  in  DATA_WIDTH  scan beat.
 pcie_valid  in  1  scan beat strobe.
 pcie_start  in  1  frame-start pulse.
 pcie_stop  in  1  frame-stop pulse.
 s0_axis_c2h_tready_i  in  1  DMA ready.
 s0_axis_c2h_tdata_o/tkeep_o/tuser_o/tlast_o/tvalid_o  out  DATA_WIDTH/KEEP_WIDTH/KEEP_WIDTH/1/1  C2H stream.
 irq_req_o  out  1  frame-done interrupt request.
 irq_ack_i  in  1  interrupt acknowledge.
 busy_o  out  1  high in any state except IDLE.
 ovf_cnt_o  out  16  dropped-beat count, saturating.

Function
REQ-005 States: IDLE, CAPTURE, FLUSH, IRQ.
REQ-006 IDLE->CAPTURE when c2h_run_i=1 and pcie_start=1 and pcie_stop=0; start and stop in the same IDLE cycle leave the block in IDLE.
REQ-007 CAPTURE->FLUSH on pcie_stop=1 or c2h_run_i=0; pcie_start is ignored in CAPTURE.
REQ-008 FLUSH->IRQ when the FIFO and output register are both empty; IRQ->IDLE on the cycle irq_ack_i=1.
REQ-009 pcie_valid beats are written to the FIFO only in CAPTURE, including the pcie_start cycle and the pcie_stop cycle.
REQ-010 A beat arriving with the FIFO full is dropped; ovf_cnt_o increments by 1 and saturates at 0xFFFF.
REQ-011 ovf_cnt_o clears on the IDLE->CAPTURE transition.
REQ-012 Output is one registered AXIS stage. tdata and tlast stay stable while tvalid=1 and tready=0.
REQ-013 With tready held high, first-beat latency is 2 cycles from the pcie_valid write, subject to REQ-014.
REQ-014 Lookahead rule: in CAPTURE, a beat is presented only if a successor entry is in the FIFO or the beat closes a packet; in FLUSH, all remaining beats are presented.
REQ-015 tlast=1 on beat number pkt_beats_i within a packet, and on the final beat of the frame. The beat counter resets after each tlast.
REQ-016 pkt_beats_i is sampled at IDLE->CAPTURE and held for the whole frame.
REQ-017 tkeep_o is all ones and tuser_o is 0 on every beat.
REQ-018 A frame with zero captured beats produces no AXIS beat and still enters IRQ.
REQ-019 irq_req_o is high throughout IRQ and drops the cycle after the ack.
REQ-020 c2h_rst_i=1 in any state: the FIFO and output register empty, tvalid drops the next cycle, the state goes to IDLE, and no IRQ is raised. c2h_rst_i has priority over all other inputs.
REQ-021 Full throughput: 1 beat per cycle sustained when tready=1 and the FIFO is non-empty.

Reset
REQ-022 On usr_rst_n=0, asynchronously: state=IDLE; FIFO pointers 0; tvalid_o, tlast_o, irq_req_o, busy_o=0; tdata_o, tkeep_o, tuser_o=0; ovf_cnt_o=0; beat counter 0.
REQ-023 Reset release needs no input sequencing; the first pcie_start is honoured from the second clock after deassertion.

Structure
REQ-024 State encodings, FIFO_DEPTH default and the 4096 packet-length rule belong in the shared parameter definition header used by the sgdma application blocks.
REQ-025 The capture buffer is one sub-module, c2h_sync_fifo: synchronous, with full/empty flags and a registered read, and its own flush input driven by c2h_rst_i.

Verification
REQ-026 pkt_beats=4, 8 contiguous beats, then stop, tready=1 -> 2 packets of 4 beats, tlast on beats 4 and 8, data in order, then irq_req_o=1.
REQ-027 pkt_beats=4, 6 beats, then stop -> packets of 4 and 2 beats, each with tlast; irq_req_o holds until ack, then busy_o=0.
REQ-028 FIFO_DEPTH=64, tready=0, 70 beats -> ovf_cnt_o=6; after tready=1 and stop, exactly 64 beats are emitted with tlast on the 64th.
REQ-029 tready toggling 1/0 every cycle during a 16-beat frame -> no data loss or duplication, and tdata is stable during stalls.
REQ-030 c2h_rst_i pulse mid-frame after 3 beats -> tvalid=0 next cycle, state IDLE, no irq_req_o; a new start then captures normally.
REQ-031 Start then stop with no pcie_valid -> zero AXIS beats and irq_req_o=1; start and stop in the same cycle in IDLE -> no state change.
